// File: rtl/lcd_inst_pkg.sv
// Shared definitions for the HD44780 controller: controller states, the
// power-on init opcodes and small elaboration-time helpers.
package lcd_inst_pkg;

  typedef enum logic [2:0] {
    POWERUP,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC_WAIT
  } lcd_state_t;

  localparam logic [7:0] LCD_FUNC_SET_8BIT   = 8'h38;
  localparam logic [7:0] LCD_DISP_ON_CUR_OFF = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC       = 8'h06;
  localparam logic [7:0] LCD_CLEAR           = 8'h01;

  localparam int INIT_LEN = 6;

  // Function set is sent three times so the panel locks into 8-bit mode.
  function automatic logic [7:0] init_opcode(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_opcode = LCD_FUNC_SET_8BIT;
      3'd3:             init_opcode = LCD_DISP_ON_CUR_OFF;
      3'd4:             init_opcode = LCD_ENTRY_INC;
      3'd5:             init_opcode = LCD_CLEAR;
      default:          init_opcode = 8'h00;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    max_int = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter that times every controller phase; done marks the
// last cycle of a phase and a zero load value behaves like one.
module lcd_delay_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done,
  output logic         empty
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= (load_value == '0) ? W'(1) : load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done  = (count == W'(1));
  assign empty = (count == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// Avalon-MM slave driving an HD44780 character LCD in 8-bit mode: runs the
// power-on init table, then bit-bangs each accepted instruction or character.
module lcd_hd44780_ctrl
  import lcd_inst_pkg::*;
#(
  parameter int POWERUP_CYC = 750000,
  parameter int SETUP_CYC   = 2,
  parameter int EN_HIGH_CYC = 25,
  parameter int HOLD_CYC    = 2,
  parameter int EXEC_CYC    = 2500,
  parameter int CLEAR_CYC   = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       address,
  input  logic       chipselect,
  input  logic       byteenable,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic       waitrequest,
  output logic [7:0] readdata,
  output logic [1:0] response,
  output logic [7:0] lcd_data,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_on,
  output logic       lcd_blon
);

  localparam int MAX_CYC = max_int(max_int(max_int(POWERUP_CYC, SETUP_CYC),
                                           max_int(EN_HIGH_CYC, HOLD_CYC)),
                                   max_int(EXEC_CYC, CLEAR_CYC));
  localparam int CW = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] POWERUP_LD = CW'(POWERUP_CYC);
  localparam logic [CW-1:0] SETUP_LD   = CW'(SETUP_CYC);
  localparam logic [CW-1:0] EN_LD      = CW'(EN_HIGH_CYC);
  localparam logic [CW-1:0] HOLD_LD    = CW'(HOLD_CYC);
  localparam logic [CW-1:0] EXEC_LD    = CW'(EXEC_CYC);
  localparam logic [CW-1:0] CLEAR_LD   = CW'(CLEAR_CYC);

  lcd_state_t    state, state_next;
  logic          init_done;
  logic [2:0]    init_idx;
  logic          load;
  logic [CW-1:0] load_value;
  logic          cnt_done, cnt_empty;
  logic          load_pins, pins_rs;
  logic [7:0]    pins_data;
  logic          init_step, init_finish;
  logic          use_clear;
  logic          unused_inputs;

  assign unused_inputs = &{1'b0, byteenable, read};

  lcd_delay_counter #(.W(CW)) u_delay (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .done       (cnt_done),
    .empty      (cnt_empty)
  );

  // Clear (0x00/0x01) and home (0x02/0x03) take the long execution time, as
  // does every init-table entry.
  assign use_clear = !init_done || (!lcd_rs && (lcd_data[7:1] <= 7'd1));

  assign waitrequest = chipselect && write && !((state == IDLE) && init_done);
  assign readdata    = {(state != IDLE), init_done, 6'b0};
  assign response    = 2'b00;
  assign lcd_rw      = 1'b0;

  always_comb begin
    state_next  = state;
    load        = 1'b0;
    load_value  = '0;
    load_pins   = 1'b0;
    pins_rs     = 1'b0;
    pins_data   = '0;
    init_step   = 1'b0;
    init_finish = 1'b0;
    case (state)
      POWERUP: begin
        if (cnt_empty) begin
          load       = 1'b1;
          load_value = POWERUP_LD;
        end else if (cnt_done) begin
          state_next = SETUP;
          load       = 1'b1;
          load_value = SETUP_LD;
          load_pins  = 1'b1;
          pins_data  = init_opcode(3'd0);
        end
      end
      IDLE: begin
        if (chipselect && write && init_done) begin
          state_next = SETUP;
          load       = 1'b1;
          load_value = SETUP_LD;
          load_pins  = 1'b1;
          pins_rs    = address;
          pins_data  = writedata;
        end
      end
      SETUP: begin
        if (cnt_done) begin
          state_next = PULSE;
          load       = 1'b1;
          load_value = EN_LD;
        end
      end
      PULSE: begin
        if (cnt_done) begin
          state_next = HOLD;
          load       = 1'b1;
          load_value = HOLD_LD;
        end
      end
      HOLD: begin
        if (cnt_done) begin
          state_next = EXEC_WAIT;
          load       = 1'b1;
          load_value = use_clear ? CLEAR_LD : EXEC_LD;
        end
      end
      EXEC_WAIT: begin
        // While init is running, chain straight into the next table entry.
        if (cnt_done) begin
          if (init_done) begin
            state_next = IDLE;
          end else if (init_idx == 3'(INIT_LEN - 1)) begin
            state_next  = IDLE;
            init_finish = 1'b1;
          end else begin
            state_next = SETUP;
            load       = 1'b1;
            load_value = SETUP_LD;
            load_pins  = 1'b1;
            pins_data  = init_opcode(init_idx + 3'd1);
            init_step  = 1'b1;
          end
        end
      end
      default: state_next = POWERUP;
    endcase
  end

  // Pins are registered from the next state so lcd_en cannot glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= POWERUP;
      init_done <= 1'b0;
      init_idx  <= 3'd0;
      lcd_en    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
      lcd_on    <= 1'b0;
      lcd_blon  <= 1'b0;
    end else begin
      state    <= state_next;
      lcd_en   <= (state_next == PULSE);
      lcd_on   <= 1'b1;
      lcd_blon <= 1'b1;
      if (load_pins) begin
        lcd_rs   <= pins_rs;
        lcd_data <= pins_data;
      end
      if (init_step) init_idx <= init_idx + 3'd1;
      if (init_finish) init_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl: an expected LCD byte stream plus
// timing rules is checked every cycle by a pin monitor.
module tb_lcd_hd44780_ctrl;

  localparam int P_POWERUP = 20;
  localparam int P_SETUP   = 2;
  localparam int P_EN      = 4;
  localparam int P_HOLD    = 2;
  localparam int P_EXEC    = 10;
  localparam int P_CLEAR   = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic       address, chipselect, byteenable, read, write;
  logic [7:0] writedata;
  logic       waitrequest;
  logic [7:0] readdata;
  logic [1:0] response;
  logic [7:0] lcd_data;
  logic       lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
  } item_t;

  item_t exp_q[$];

  lcd_hd44780_ctrl #(
    .POWERUP_CYC (P_POWERUP),
    .SETUP_CYC   (P_SETUP),
    .EN_HIGH_CYC (P_EN),
    .HOLD_CYC    (P_HOLD),
    .EXEC_CYC    (P_EXEC),
    .CLEAR_CYC   (P_CLEAR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .byteenable  (byteenable),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .response    (response),
    .lcd_data    (lcd_data),
    .lcd_en      (lcd_en),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_on      (lcd_on),
    .lcd_blon    (lcd_blon)
  );

  always #5 clk = ~clk;

  function automatic int exec_cycles(input logic rs, input logic [7:0] d);
    return (!rs && d <= 8'h03) ? P_CLEAR : P_EXEC;
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Back-to-back init commands are separated by hold + clear wait + setup.
  task automatic push_init();
    logic [7:0] ops [6];
    ops = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
    for (int i = 0; i < 6; i++)
      exp_q.push_back('{1'b0, ops[i], (i == 0) ? 0 : 34});
  endtask

  task automatic apply_write(input logic a, input logic [7:0] d, input int exp_stall);
    int stall;
    stall = 0;
    exp_q.push_back('{a, d, 0});
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    @(negedge clk);
    while (waitrequest && stall < 400) begin
      stall++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
    check_output("write_stall", stall, exp_stall);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    chipselect = 1'b1;
    read       = 1'b1;
    @(negedge clk);
    while (readdata !== 8'h40 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check_output("idle_status", readdata, 8'h40);
    check_output("idle_response", response, 0);
    read       = 1'b0;
    chipselect = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Pin monitor: byte order, setup, pulse width, hold and init spacing.
  logic       prev_en;
  logic [8:0] prev_pins;
  int         high_len, since_fall, stable_len;
  logic       fell;

  always @(negedge clk) begin
    if (reset) begin
      prev_en    = 1'b0;
      prev_pins  = '0;
      high_len   = 0;
      since_fall = 0;
      stable_len = 0;
      fell       = 1'b0;
    end else begin
      logic  changed;
      item_t it;
      check_output("lcd_rw", lcd_rw, 0);
      check_output("lcd_on_blon", {lcd_on, lcd_blon}, 2'b11);
      changed    = ({lcd_rs, lcd_data} != prev_pins);
      stable_len = changed ? 1 : stable_len + 1;
      if (!lcd_en && !prev_en && fell) since_fall++;
      if (changed)
        check_output("pins_held", (lcd_en || prev_en || (fell && since_fall <= P_HOLD)) ? 1 : 0, 0);
      if (lcd_en && !prev_en) begin
        if (exp_q.size() == 0) begin
          report_fail("unexpected_pulse");
        end else begin
          it = exp_q.pop_front();
          check_output("lcd_byte", {lcd_rs, lcd_data}, {it.rs, it.data});
          check_output("setup_time", (stable_len > P_SETUP) ? 1 : 0, 1);
          if (it.gap > 0) check_output("init_gap", since_fall, it.gap);
        end
        high_len = 1;
        fell     = 1'b0;
      end else if (lcd_en) begin
        high_len++;
      end else if (prev_en) begin
        check_output("en_width", high_len, P_EN);
        fell       = 1'b1;
        since_fall = 1;
      end
      prev_en   = lcd_en;
      prev_pins = {lcd_rs, lcd_data};
    end
  end

  initial begin
    #500000;
    report_fail("watchdog_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    logic [7:0] scr [13];
    logic       prev_rs;
    logic [7:0] prev_d;
    int         n;

    reset      = 1'b1;
    address    = 1'b0;
    chipselect = 1'b0;
    byteenable = 1'b1;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = 8'h00;
    #12;
    check_output("rst_pins", {lcd_en, lcd_rs, lcd_data, lcd_on, lcd_blon}, 0);
    check_output("rst_status", readdata, 8'h80);
    check_output("rst_waitreq", waitrequest, 0);

    @(negedge clk);
    #1 reset = 1'b0;
    push_init();

    // Writes (with a simultaneous read) are stalled throughout init.
    @(posedge clk);
    #1;
    chipselect = 1'b1;
    write      = 1'b1;
    read       = 1'b1;
    writedata  = 8'h55;
    repeat (40) begin
      @(negedge clk);
      check_output("init_stall", waitrequest, 1);
      check_output("init_status", readdata, 8'h80);
    end
    write      = 1'b0;
    read       = 1'b0;
    chipselect = 1'b0;
    wait_idle();
    check_output("init_stream_done", exp_q.size(), 0);

    // Character then an immediately following write: stalled exactly 18 cycles.
    apply_write(1'b1, 8'h43, 0);
    apply_write(1'b1, 8'h44, 18);
    wait_idle();

    // Clear/home use the long wait, display-on the short one.
    apply_write(1'b0, 8'h01, 0);
    apply_write(1'b0, 8'h02, 38);
    apply_write(1'b0, 8'h0C, 38);
    apply_write(1'b1, 8'h41, 18);
    wait_idle();

    // Read while busy is served without stalling.
    apply_write(1'b1, 8'h58, 0);
    chipselect = 1'b1;
    read       = 1'b1;
    #1;
    check_output("busy_status", readdata, 8'hC0);
    check_output("busy_read_wait", waitrequest, 0);
    check_output("busy_response", response, 0);
    read       = 1'b0;
    chipselect = 1'b0;
    wait_idle();

    // Full screen from a master writing back to back.
    scr = '{8'h01, 8'h0C, "C", "m", "d", ":", "3", " ", "D", "r", ":", "1", "7"};
    prev_rs = 1'b0;
    prev_d  = 8'h00;
    for (int i = 0; i < 13; i++) begin
      apply_write((i >= 2), scr[i],
                  (i == 0) ? 0 : P_SETUP + P_EN + P_HOLD + exec_cycles(prev_rs, prev_d));
      prev_rs = (i >= 2);
      prev_d  = scr[i];
    end
    wait_idle();
    check_output("screen_stream_done", exp_q.size(), 0);

    // Reset in the middle of an enable pulse.
    apply_write(1'b1, 8'h5A, 0);
    n = 0;
    while (!lcd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("pulse_reached", lcd_en, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("async_rst_pins", {lcd_en, lcd_rs, lcd_data, lcd_on, lcd_blon}, 0);
    check_output("async_rst_status", readdata, 8'h80);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    push_init();
    wait_idle();
    check_output("reinit_stream_done", exp_q.size(), 0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_ctrl.md
LCD_HD44780_CTRL -- requirements
Module: lcd_hd44780_ctrl

Interface
REQ-001 SHALL have parameters: POWERUP_CYC, default 750000, power-on wait before init (15 ms at 50 MHz).
REQ-002 SHALL have parameters: SETUP_CYC, default 2, RS/DATA setup before EN rise.
REQ-003 SHALL have parameters: EN_HIGH_CYC, default 25, EN pulse width.
REQ-004 SHALL have parameters: HOLD_CYC, default 2, RS/DATA hold after EN fall.
REQ-005 SHALL have parameters: EXEC_CYC, default 2500, normal command/data execution wait (50 us).
REQ-006 SHALL have parameters: CLEAR_CYC, default 82000, clear/home execution wait (1.64 ms).
REQ-007 SHALL have port clk, input, 1, sole clock.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port address, input, 1, 0 = instruction, 1 = character data (RS).
REQ-010 SHALL have port chipselect, input, 1, Avalon-MM select.
REQ-011 SHALL have port byteenable, input, 1, ignored.
REQ-012 SHALL have port read, input, 1, status read strobe.
REQ-013 SHALL have port write, input, 1, write strobe.
REQ-014 SHALL have port writedata, input, 8, instruction or character byte.
REQ-015 SHALL have port waitrequest, output, 1, stall to master.
REQ-016 SHALL have port readdata, output, 8, status {busy, init_done, 6'b0}.
REQ-017 SHALL have port response, output, 2, always 2'b00 (OKAY).
REQ-018 SHALL have port lcd_data, output, 8, HD44780 DB7..DB0.
REQ-019 SHALL have ports lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon, output, 1 each: enable, register select, read/write (constant 0), panel power, backlight.

Function
REQ-020 SHALL implement FSM states POWERUP, IDLE, SETUP, PULSE, HOLD, EXEC_WAIT, with INIT handled as a flag plus init-table index over the same SETUP..EXEC_WAIT path.
REQ-021 SHALL go POWERUP -> (POWERUP_CYC elapsed) -> issue init table 0x38, 0x38, 0x38, 0x0C, 0x06, 0x01 as instructions (rs=0), each followed by a CLEAR_CYC wait; after the last, set init_done=1 and enter IDLE.
REQ-022 SHALL accept a write only in IDLE with init_done=1: waitrequest low in the accept cycle; latch address and writedata; next state SETUP.
REQ-023 SHALL drive waitrequest = chipselect & write & !(IDLE & init_done), combinationally; stalled writes change no state.
REQ-024 SHALL serve reads without stalling: waitrequest low and readdata valid in the same cycle; read ignored for FSM.
REQ-025 SHALL treat simultaneous read and write as a write for handshake; readdata still shows status.
REQ-026 SHALL sequence: SETUP holds rs/data for SETUP_CYC with en=0; PULSE en=1 for EN_HIGH_CYC; HOLD en=0 for HOLD_CYC with rs/data unchanged; EXEC_WAIT for EXEC_CYC or CLEAR_CYC; then IDLE.
REQ-027 SHALL use CLEAR_CYC when rs=0 and writedata[7:1] == 7'b0000000 (0x01 clear) or == 7'b0000001 (0x02/0x03 home); EXEC_CYC otherwise.
REQ-028 SHALL set busy=1 in every state except IDLE; busy=1 during POWERUP/init.
REQ-029 SHALL use a single down-counter sized $clog2(max parameter)+1 bits, loaded on state entry, state advance at count==1; a parameter of 0 SHALL be treated as 1.
REQ-030 SHALL register all LCD pins (no combinational glitches on lcd_en).
REQ-031 SHALL keep lcd_rw=0 always; lcd_on=lcd_blon=1 in every state after reset.

Reset
REQ-032 SHALL, on reset assertion at any time (including mid-PULSE), immediately force lcd_en=0, lcd_rs=0, lcd_data=0, lcd_on=0, lcd_blon=0, init_done=0, counter=0, state=POWERUP, without waiting for a clock edge.
REQ-033 SHALL restart the full power-up and init sequence after reset release.

Structure
REQ-034 SHALL place init-table opcodes (LCD_FUNC_SET_8BIT=0x38, LCD_DISP_ON_CUR_OFF=0x0C, LCD_ENTRY_INC=0x06, LCD_CLEAR=0x01) and the state typedef in lcd_inst_pkg.
REQ-035 SHALL factor the load/count/done timer into one sub-module, lcd_delay_counter.

Verification (sim parameters: POWERUP 20, SETUP 2, EN_HIGH 4, HOLD 2, EXEC 10, CLEAR 30)
REQ-036 SHALL cover: reset release -> lcd_data 0x38,0x38,0x38,0x0C,0x06,0x01 with rs=0, each en pulse 4 cycles, 30-cycle gaps; readdata 0x80 during init, 0x40 after; writes stalled throughout.
REQ-037 SHALL cover: write addr=1, data=0x43 -> waitrequest low in accept cycle, rs=1, data stable 2 cycles before en, en high 4 cycles, held 2 cycles; next write stalled exactly 18 cycles.
REQ-038 SHALL cover: instruction 0x01 and 0x02 -> 30-cycle exec wait; 0x0C -> 10-cycle wait.
REQ-039 SHALL cover: upstream display master model sends 13-byte screen (0x01, 0x0C, 'C','m','d',':','3',' ','D','r',':','1','7') -> captured LCD byte/rs stream identical, none dropped or duplicated.
REQ-040 SHALL cover: read while busy -> waitrequest low, readdata 0xC0, response 00; idle read -> 0x40.
REQ-041 SHALL cover: reset asserted mid-PULSE -> lcd_en falls with no clock edge; after release, init sequence repeats from first 0x38.
